// File: rtl/universal_shift_register_n_bits.sv
// Parametrised universal shift register: load, shift, rotate, arithmetic shift and clear,
// multi-step commands run one bit per clock under a Start/Busy/Done handshake.
module universal_shift_register_n_bits #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned CNT_W = $clog2(WIDTH) + 1
) (
  input  logic             Clk_In,
  input  logic             Reset_In,
  input  logic             Start_In,
  input  logic [2:0]       Mode_In,
  input  logic [CNT_W-1:0] Shift_Count_In,
  input  logic [WIDTH-1:0] Parallel_Data_In,
  input  logic             Serial_Left_In,
  input  logic             Serial_Right_In,
  output logic [WIDTH-1:0] Parallel_Data_Out,
  output logic             Serial_Left_Out,
  output logic             Serial_Right_Out,
  output logic             Busy_Out,
  output logic             Done_Out
);

  typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

  localparam logic [2:0] ModeHold  = 3'b000;
  localparam logic [2:0] ModeLoad  = 3'b001;
  localparam logic [2:0] ModeShl   = 3'b010;
  localparam logic [2:0] ModeShr   = 3'b011;
  localparam logic [2:0] ModeRol   = 3'b100;
  localparam logic [2:0] ModeRor   = 3'b101;
  localparam logic [2:0] ModeAsr   = 3'b110;
  localparam logic [2:0] ModeClear = 3'b111;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] data_q, data_d;
  logic [WIDTH-1:0] load_q, load_d;
  logic [2:0]       mode_q, mode_d;
  logic [CNT_W-1:0] remaining_q, remaining_d;
  logic             armed_q;
  logic [WIDTH-1:0] step_val;
  logic             single_step;

  // Blocks a Start on the reset-release edge; commands are taken only once this is set.
  always_ff @(posedge Clk_In or negedge Reset_In) begin
    if (!Reset_In) begin
      armed_q <= 1'b0;
    end else begin
      armed_q <= 1'b1;
    end
  end

  always_ff @(posedge Clk_In or negedge Reset_In) begin
    if (!Reset_In) begin
      state_q     <= StIdle;
      data_q      <= '0;
      load_q      <= '0;
      mode_q      <= ModeHold;
      remaining_q <= '0;
    end else begin
      state_q     <= state_d;
      data_q      <= data_d;
      load_q      <= load_d;
      mode_q      <= mode_d;
      remaining_q <= remaining_d;
    end
  end

  always_comb begin
    step_val = data_q;
    unique case (mode_q)
      ModeHold:  step_val = data_q;
      ModeLoad:  step_val = load_q;
      ModeShl:   step_val = {data_q[WIDTH-2:0], Serial_Right_In};
      ModeShr:   step_val = {Serial_Left_In, data_q[WIDTH-1:1]};
      ModeRol:   step_val = {data_q[WIDTH-2:0], data_q[WIDTH-1]};
      ModeRor:   step_val = {data_q[0], data_q[WIDTH-1:1]};
      ModeAsr:   step_val = {data_q[WIDTH-1], data_q[WIDTH-1:1]};
      ModeClear: step_val = '0;
      default:   step_val = data_q;
    endcase
  end

  assign single_step = (Mode_In == ModeHold) || (Mode_In == ModeLoad) ||
                       (Mode_In == ModeClear);

  always_comb begin
    state_d     = state_q;
    data_d      = data_q;
    load_d      = load_q;
    mode_d      = mode_q;
    remaining_d = remaining_q;
    unique case (state_q)
      StIdle: begin
        if (Start_In && armed_q) begin
          mode_d      = Mode_In;
          load_d      = Parallel_Data_In;
          remaining_d = single_step ? CNT_W'(1) : Shift_Count_In;
          state_d     = StRun;
        end
      end
      StRun: begin
        if (remaining_q != '0) begin
          data_d      = step_val;
          remaining_d = remaining_q - CNT_W'(1);
        end
        // A zero count still passes through RUN for one cycle.
        if (remaining_q <= CNT_W'(1)) begin
          state_d = StDone;
        end
      end
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  assign Parallel_Data_Out = data_q;
  assign Serial_Left_Out   = data_q[WIDTH-1];
  assign Serial_Right_Out  = data_q[0];
  assign Busy_Out          = (state_q == StRun);
  assign Done_Out          = (state_q == StDone);

endmodule

// File: doc/universal_shift_register_n_bits.md
# universal_shift_register_n_bits

Parametrised universal shift register, the successor to the fixed 8-bit parallel-in/parallel-out register. It adds:
- generic width;
- eight operating modes: load, logical shift, rotate, arithmetic shift, clear;
- multi-step shifts executed one bit per clock under a Start/Busy/Done handshake;
- serial taps at both ends for cascading.

It sits between a controller issuing commands and datapath logic that consumes the register contents.

## Interface
- WIDTH, 8: register width in bits; must be ≥2.
- CNT_W, $clog2(WIDTH)+1: width of the shift-count field; counts 0..2^CNT_W-1 are legal.

- Clk_In  input  1  system clock; all state changes on the rising edge.
- Reset_In  input  1  one clock; reset is asynchronous and active-low. Low clears all state immediately.
- Start_In  input  1  command strobe; sampled only in IDLE.
- Mode_In  input  3  operation code; sampled with Start_In.
- Shift_Count_In  input  CNT_W  number of single-bit steps; sampled with Start_In.
- Parallel_Data_In  input  WIDTH  load value; sampled with Start_In.
- Serial_Left_In  input  1  bit entering the MSB on logical right shift; sampled live at each step.
- Serial_Right_In  input  1  bit entering the LSB on left shift; sampled live at each step.
- Parallel_Data_Out  output  WIDTH  register contents.
- Serial_Left_Out  output  1  equals Parallel_Data_Out[WIDTH-1].
- Serial_Right_Out  output  1  equals Parallel_Data_Out[0].
- Busy_Out  output  1  high while the FSM is in RUN.
- Done_Out  output  1  one-cycle pulse when the FSM is in DONE.

## Operation
Mode codes:
- 000 hold: no change; the handshake still completes.
- 001 load: register takes the latched Parallel_Data_In.
- 010 shift left: {R[WIDTH-2:0], Serial_Right_In}.
- 011 shift right: {Serial_Left_In, R[WIDTH-1:1]}.
- 100 rotate left: {R[WIDTH-2:0], R[WIDTH-1]}.
- 101 rotate right: {R[0], R[WIDTH-1:1]}.
- 110 arithmetic shift right: {R[WIDTH-1], R[WIDTH-1:1]}.
- 111 clear: register becomes 0.

Steps per command:
- Modes 000, 001 and 111 are single-step; Shift_Count_In is ignored and the step count is forced to 1.
- Shift and rotate modes execute exactly Shift_Count_In steps. Counts ≥ WIDTH are executed literally: rotates wrap, logical shifts fill completely with serial input, arithmetic shifts saturate to all-sign.

FSM states: IDLE, RUN, DONE.
- IDLE: if Start_In=1, latch Mode_In, the step count and Parallel_Data_In into internal registers, then go to RUN. Otherwise stay in IDLE.
- RUN, on each edge:
  - if Remaining≠0, perform one step and decrement Remaining;
  - if Remaining≤1 at that edge (including 0), go to DONE;
  - Start_In, Mode_In, Shift_Count_In and Parallel_Data_In are ignored.
- DONE: unconditionally return to IDLE on the next edge. Start_In is ignored in DONE.
- A count of 0 gives RUN→DONE with no data change.

Reset (Reset_In low, at any time, including mid-command):
- Parallel_Data_Out=0, so Serial_Left_Out=0 and Serial_Right_Out=0.
- Busy_Out=0, Done_Out=0, state=IDLE, Remaining=0, latched registers=0.
- An in-flight command is aborted and not resumed.
- Release is synchronous to the next rising edge. No Start is accepted on the release edge itself, only from the first edge with Reset_In already high.

## Timing
Let E0 be the edge that accepts Start in IDLE.
- Step k occurs at edge Ek, for k=1..N (N = effective step count).
- Busy_Out is high from after E0 until after EN, i.e. N cycles; one cycle when N=0 or for a single-step mode.
- Done_Out is high for exactly one cycle, between EN and EN+1 (E1 and E2 when N=0).
- The earliest next Start is sampled at EN+2. Command-to-command throughput is N+2 cycles.
- Parallel_Data_Out and the serial outputs change only on step edges. No combinational path exists from any input to any output.
- Serial_Left_In and Serial_Right_In are sampled at each step edge, not latched at E0.

## Test plan
1. Reset, then assert Reset_In low while Busy_Out=1 mid-shift → all outputs 0 immediately; after release, no Done_Out pulse occurs.
2. WIDTH=8, load 0xA5, then rotate-left with count 3 → Parallel_Data_Out=0x2D after E3; Busy_Out high 3 cycles; Done_Out is one pulse at E3.
3. Load 0x81, then shift-right with count 2 and Serial_Left_In=1 held → 0xE0; Serial_Right_Out sequence is 1, 0, 0.
4. Load 0x90, then arithmetic shift right with count 10 → 0xFF. Load 0x10, then arithmetic shift right with count 4 → 0x01.
5. Shift-left with count 0 → no data change; Busy_Out high 1 cycle, then a Done_Out pulse.
6. Pulse Start_In with mode=clear during RUN of a rotate with count 5 → ignored; the rotate completes with the correct value; a back-to-back Start at EN+2 is accepted.
